// File: rtl/station_pkg.sv
// Shared types and helpers for the station entry/exit sequencer and the
// plain line-follower: state encoding, motor direction polarities and the
// three-sensor steering table.
package station_pkg;

  // Legacy numeric encodings, kept so older blocks and dumps decode the same
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND    = 3'd1;
  localparam logic [2:0] S_FWD     = 3'd2;
  localparam logic [2:0] S_FWD_GAP = 3'd3;
  localparam logic [2:0] S_REV     = 3'd4;
  localparam logic [2:0] S_REV_GAP = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_FAULT   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_SEND    = S_SEND,
    ST_FWD     = S_FWD,
    ST_FWD_GAP = S_FWD_GAP,
    ST_REV     = S_REV,
    ST_REV_GAP = S_REV_GAP,
    ST_DONE    = S_DONE,
    ST_FAULT   = S_FAULT
  } station_state_t;

  // The right motor is mounted mirrored, so its forward direction is 0
  localparam logic L_FWD = 1'b1;
  localparam logic R_FWD = 1'b0;

  // Steering table on {l,m,r} (1 = black). Returns {l_reset, l_dir, r_reset, r_dir}.
  // A motor that is switched off reports direction 0.
  function automatic logic [3:0] steer(input logic l, input logic m, input logic r);
    logic [3:0] s;
    case ({l, m, r})
      3'b000:  s = {1'b0, L_FWD,  1'b0, R_FWD};
      3'b001:  s = {1'b1, 1'b0,   1'b0, R_FWD};
      3'b010:  s = {1'b0, L_FWD,  1'b0, R_FWD};
      3'b011:  s = {1'b0, ~L_FWD, 1'b0, R_FWD};
      3'b100:  s = {1'b0, L_FWD,  1'b1, 1'b0};
      3'b101:  s = {1'b0, L_FWD,  1'b0, R_FWD};
      3'b110:  s = {1'b0, L_FWD,  1'b0, ~R_FWD};
      default: s = {1'b1, 1'b0,   1'b1, 1'b0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/station_steer.sv
// Combinational steering decode from the three line sensors to the two
// motor controllers. Shared with the plain line-follower block.
module station_steer (
  input  logic sensor_l,
  input  logic sensor_m,
  input  logic sensor_r,
  output logic l_reset,
  output logic l_dir,
  output logic r_reset,
  output logic r_dir
);
  import station_pkg::*;

  // Pure table lookup; any registering is left to the instantiating block
  always_comb begin
    {l_reset, l_dir, r_reset, r_dir} = steer(sensor_l, sensor_m, sensor_r);
  end

endmodule

// File: rtl/station_maneuver.sv
// Station entry/exit sequencer: announces the manoeuvre with one UART byte,
// line-follows forward for a fixed time, and in enter mode reverses until
// all three sensors see black (with a timeout to FAULT). Every output is
// registered from the next-state decode so it lines up with the state.
module station_maneuver #(
  parameter int unsigned FWD_CYCLES     = 8_000_000,
  parameter int unsigned PERIOD_CYCLES  = 2_000_000,
  parameter int unsigned REV_MAX_CYCLES = 50_000_000,
  parameter logic [7:0]  MSG_ENTER      = 8'd68,
  parameter logic [7:0]  MSG_EXIT       = 8'd69,
  parameter int unsigned CNT_W          = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       sensor_l,
  input  logic       sensor_m,
  input  logic       sensor_r,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       motor_l_reset,
  output logic       motor_r_reset,
  output logic       motor_l_direction,
  output logic       motor_r_direction,
  output logic       motor_brake,
  output logic       busy,
  output logic       done,
  output logic       error
);
  import station_pkg::*;

  localparam logic [CNT_W-1:0] FWD_LAST    = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REV_LAST    = CNT_W'(REV_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  station_state_t   state, state_nxt;
  logic             mode_q, mode_nxt;
  logic [CNT_W-1:0] phase_cnt, phase_nxt;
  logic [CNT_W-1:0] period_cnt, period_nxt;

  logic steer_l_reset, steer_l_dir, steer_r_reset, steer_r_dir;

  logic       l_reset_nxt, l_dir_nxt, r_reset_nxt, r_dir_nxt;
  logic       brake_nxt, tx_valid_nxt, busy_nxt, done_nxt, error_nxt;
  logic [7:0] tx_data_nxt;

  station_steer u_steer (
    .sensor_l (sensor_l),
    .sensor_m (sensor_m),
    .sensor_r (sensor_r),
    .l_reset  (steer_l_reset),
    .l_dir    (steer_l_dir),
    .r_reset  (steer_r_reset),
    .r_dir    (steer_r_dir)
  );

  // Next-state and counter decode; counters fall back to zero outside the
  // FWD/REV phases. Phase-end tests use >= so a phase end landing on a gap
  // cycle still terminates on the following cycle instead of wrapping.
  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    phase_nxt  = '0;
    period_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SEND;
          mode_nxt  = mode;
        end
      end
      ST_SEND: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else if (tx_valid && tx_ready) begin
          state_nxt = ST_FWD;
        end
      end
      ST_FWD: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else if (phase_cnt >= FWD_LAST) begin
          if (mode_q) state_nxt = ST_DONE;
          else        state_nxt = ST_REV;
        end else if (period_cnt >= PERIOD_LAST) begin
          state_nxt = ST_FWD_GAP;
          phase_nxt = phase_cnt + CNT_ONE;
        end else begin
          phase_nxt  = phase_cnt + CNT_ONE;
          period_nxt = period_cnt + CNT_ONE;
        end
      end
      ST_FWD_GAP: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_FWD;
          phase_nxt = phase_cnt + CNT_ONE;
        end
      end
      ST_REV: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else if (sensor_l && sensor_m && sensor_r) begin
          state_nxt = ST_DONE;
        end else if (phase_cnt >= REV_LAST) begin
          state_nxt = ST_FAULT;
        end else if (period_cnt >= PERIOD_LAST) begin
          state_nxt = ST_REV_GAP;
          phase_nxt = phase_cnt + CNT_ONE;
        end else begin
          phase_nxt  = phase_cnt + CNT_ONE;
          period_nxt = period_cnt + CNT_ONE;
        end
      end
      ST_REV_GAP: begin
        if (!start) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_REV;
          phase_nxt = phase_cnt + CNT_ONE;
        end
      end
      ST_DONE, ST_FAULT: begin
        if (!start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; defaults are the idle/off values
  always_comb begin
    l_reset_nxt  = 1'b1;
    l_dir_nxt    = 1'b0;
    r_reset_nxt  = 1'b1;
    r_dir_nxt    = 1'b0;
    brake_nxt    = 1'b0;
    tx_valid_nxt = 1'b0;
    tx_data_nxt  = 8'd0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    case (state_nxt)
      ST_SEND: begin
        brake_nxt    = 1'b1;
        tx_valid_nxt = 1'b1;
        tx_data_nxt  = mode_nxt ? MSG_EXIT : MSG_ENTER;
        busy_nxt     = 1'b1;
      end
      ST_FWD: begin
        l_reset_nxt = steer_l_reset;
        l_dir_nxt   = steer_l_dir;
        r_reset_nxt = steer_r_reset;
        r_dir_nxt   = steer_r_dir;
        busy_nxt    = 1'b1;
      end
      ST_FWD_GAP, ST_REV_GAP: begin
        busy_nxt = 1'b1;
      end
      ST_REV: begin
        l_reset_nxt = 1'b0;
        l_dir_nxt   = ~L_FWD;
        r_reset_nxt = 1'b0;
        r_dir_nxt   = ~R_FWD;
        busy_nxt    = 1'b1;
      end
      ST_DONE: begin
        brake_nxt = 1'b1;
        done_nxt  = 1'b1;
      end
      ST_FAULT: begin
        brake_nxt = 1'b1;
        error_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // State, captured mode and the phase/period counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= 1'b0;
      phase_cnt  <= '0;
      period_cnt <= '0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode_nxt;
      phase_cnt  <= phase_nxt;
      period_cnt <= period_nxt;
    end
  end

  // Registered outputs, forced to the idle values during reset
  always_ff @(posedge clk) begin
    if (reset) begin
      motor_l_reset     <= 1'b1;
      motor_l_direction <= 1'b0;
      motor_r_reset     <= 1'b1;
      motor_r_direction <= 1'b0;
      motor_brake       <= 1'b0;
      tx_valid          <= 1'b0;
      tx_data           <= 8'd0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      motor_l_reset     <= l_reset_nxt;
      motor_l_direction <= l_dir_nxt;
      motor_r_reset     <= r_reset_nxt;
      motor_r_direction <= r_dir_nxt;
      motor_brake       <= brake_nxt;
      tx_valid          <= tx_valid_nxt;
      tx_data           <= tx_data_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      error             <= error_nxt;
    end
  end

endmodule

// File: tb/tb_station_maneuver.sv
// Bench for station_maneuver. Stimulus pushes the expected sequence of
// output "segments" (a constant output vector and how many cycles it lasts)
// plus the expected UART bytes; a monitor splits the live outputs into
// segments and checks each one against the queue as it completes.
module tb_station_maneuver;

  localparam int FWD_CYCLES     = 100;
  localparam int PERIOD_CYCLES  = 20;
  localparam int REV_MAX_CYCLES = 50;

  // Output vector: {tx_valid, tx_data, l_reset, l_dir, r_reset, r_dir, brake, busy, done, error}
  localparam logic [16:0] V_IDLE  = {1'b0, 8'd0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] V_GAP   = {1'b0, 8'd0, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] V_REV   = {1'b0, 8'd0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] V_DONE  = {1'b0, 8'd0, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [16:0] V_FAULT = {1'b0, 8'd0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start, mode, sensor_l, sensor_m, sensor_r, tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, motor_l_reset, motor_r_reset, motor_l_direction, motor_r_direction;
  logic       motor_brake, busy, done, error;
  logic [16:0] obs;

  int checks = 0;
  int errors = 0;

  logic [16:0] seg_vec_q[$];
  int          seg_len_q[$];
  string       seg_name_q[$];
  logic [7:0]  tx_q[$];

  logic        mon_en = 1'b0;
  logic        seg_open = 1'b0;
  logic [16:0] cur_vec;
  int          cur_len;
  logic [7:0]  exp_byte;

  station_maneuver #(
    .FWD_CYCLES     (FWD_CYCLES),
    .PERIOD_CYCLES  (PERIOD_CYCLES),
    .REV_MAX_CYCLES (REV_MAX_CYCLES)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .mode              (mode),
    .sensor_l          (sensor_l),
    .sensor_m          (sensor_m),
    .sensor_r          (sensor_r),
    .tx_ready          (tx_ready),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .motor_l_reset     (motor_l_reset),
    .motor_r_reset     (motor_r_reset),
    .motor_l_direction (motor_l_direction),
    .motor_r_direction (motor_r_direction),
    .motor_brake       (motor_brake),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  assign obs = {tx_valid, tx_data, motor_l_reset, motor_l_direction, motor_r_reset,
                motor_r_direction, motor_brake, busy, done, error};

  // 10-unit clock
  always #5 clk = ~clk;

  // Hand table of {l_reset, l_dir, r_reset, r_dir} for each sensor code {l,m,r}
  function automatic logic [3:0] steer_exp(input logic [2:0] code);
    logic [3:0] s;
    case (code)
      3'b000:  s = 4'b0100;
      3'b001:  s = 4'b1000;
      3'b010:  s = 4'b0100;
      3'b011:  s = 4'b0000;
      3'b100:  s = 4'b0110;
      3'b101:  s = 4'b0100;
      3'b110:  s = 4'b0101;
      default: s = 4'b1010;
    endcase
    return s;
  endfunction

  function automatic logic [16:0] v_send(input logic [7:0] d);
    return {1'b1, d, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [16:0] v_fwd(input logic [2:0] code);
    return {1'b0, 8'd0, steer_exp(code), 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic md, input logic rdy, input logic [2:0] sens);
    start    = st;
    mode     = md;
    tx_ready = rdy;
    {sensor_l, sensor_m, sensor_r} = sens;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // len 0 means the segment length is set by bench idle time and is not checked
  task automatic push_seg(input string name, input logic [16:0] v, input int len);
    seg_name_q.push_back(name);
    seg_vec_q.push_back(v);
    seg_len_q.push_back(len);
  endtask

  // A timed phase of `total` cycles: runs of one period separated by a one-cycle gap
  task automatic push_phase(input string name, input logic [16:0] v, input int total);
    int left;
    int run;
    left = total;
    while (left > 0) begin
      run = (left < PERIOD_CYCLES) ? left : PERIOD_CYCLES;
      push_seg(name, v, run);
      left -= run;
      if (left > 0) begin
        push_seg({name, "_gap"}, V_GAP, 1);
        left -= 1;
      end
    end
  endtask

  task automatic close_segment(input logic [16:0] v, input int len);
    logic [16:0] ev;
    int          el;
    string       en;
    if (seg_vec_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL extra_segment: got vector %0h for %0d cycles, want none", v, len);
    end else begin
      ev = seg_vec_q.pop_front();
      el = seg_len_q.pop_front();
      en = seg_name_q.pop_front();
      checkOutput({en, "_vec"}, 32'(v), 32'(ev));
      if (el != 0) checkOutput({en, "_len"}, len, el);
    end
  endtask

  // Monitor: checks UART handshakes and splits outputs into constant-vector segments
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_tx_byte: got %0d, want no transfer", tx_data);
          end else begin
            exp_byte = tx_q.pop_front();
            checkOutput("tx_byte", 32'(tx_data), 32'(exp_byte));
          end
        end
        if (!seg_open) begin
          seg_open = 1'b1;
          cur_vec  = obs;
          cur_len  = 1;
        end else if (obs === cur_vec) begin
          cur_len++;
        end else begin
          close_segment(cur_vec, cur_len);
          cur_vec = obs;
          cur_len = 1;
        end
      end
    end
  end

  // Directed scenarios; cycle comments count from the cycle start is raised
  initial begin : stimulus
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    push_seg("reset_idle", V_IDLE, 0);
    wait_cycles(2);
    mon_en = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(3);

    $display("[TB] enter, happy path");
    tx_q.push_back(8'd68);
    push_seg("enter_send", v_send(8'd68), 1);
    push_phase("enter_fwd", v_fwd(3'b010), FWD_CYCLES);
    push_seg("enter_rev", V_REV, 20);
    push_seg("enter_rev_gap", V_GAP, 1);
    push_seg("enter_rev", V_REV, 10);
    push_seg("enter_done", V_DONE, 5);
    push_seg("idle", V_IDLE, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b010);
    wait_cycles(132);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b111);
    wait_cycles(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b111);
    wait_cycles(4);

    $display("[TB] steering sweep, then abort mid-FWD");
    tx_q.push_back(8'd68);
    push_seg("sweep_send", v_send(8'd68), 1);
    for (int c = 0; c < 8; c++) push_seg($sformatf("steer_%03b", c), v_fwd(3'(c)), 2);
    push_seg("abort_idle", V_IDLE, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
    wait_cycles(1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 3'(i));
      wait_cycles(2);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b111);
    wait_cycles(4);

    $display("[TB] UART backpressure, then reset mid-REV");
    tx_q.push_back(8'd68);
    push_seg("bp_send", v_send(8'd68), 37);
    push_phase("bp_fwd", v_fwd(3'b010), FWD_CYCLES);
    push_seg("bp_rev", V_REV, 11);
    push_seg("reset_idle", V_IDLE, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b010);
    wait_cycles(37);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b010);
    wait_cycles(111);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);

    $display("[TB] exit, then restart on the DONE exit cycle into a reverse timeout");
    tx_q.push_back(8'd69);
    push_seg("exit_send", v_send(8'd69), 1);
    push_phase("exit_fwd", v_fwd(3'b010), FWD_CYCLES);
    push_seg("exit_done", V_DONE, 8);
    push_seg("restart_idle", V_IDLE, 1);
    tx_q.push_back(8'd68);
    push_seg("to_send", v_send(8'd68), 1);
    push_phase("to_fwd", v_fwd(3'b010), FWD_CYCLES);
    push_phase("to_rev", V_REV, REV_MAX_CYCLES);
    push_seg("to_fault", V_FAULT, 6);
    push_seg("final_idle", V_IDLE, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b010);
    wait_cycles(109);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b010);
    wait_cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b010);
    wait_cycles(157);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010);
    wait_cycles(5);

    mon_en = 1'b0;
    close_segment(cur_vec, cur_len);
    checkOutput("pending_segments", seg_vec_q.size(), 0);
    checkOutput("pending_tx_bytes", tx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/station_maneuver.md
Name: station_maneuver

Overview:
- Parametrised station entry/exit sequencer for the line-following robot.
- On a level request it:
  - announces the manoeuvre over UART with a single byte;
  - line-follows forward for a programmable time;
  - in enter mode only, reverses until all three sensors see black.
- Owns its phase and motor-period timers; no external count input.
- Sits between the top-level route controller and the two servo motor controllers and the UART transmitter.

Parameters:
- FWD_CYCLES, 8_000_000: forward line-follow duration, in clk cycles (80 ms at 100 MHz).
- PERIOD_CYCLES, 2_000_000: motor-controller refresh period. A one-cycle motor reset is inserted at the end of each period.
- REV_MAX_CYCLES, 50_000_000: enter-mode reverse timeout; reaching it goes to FAULT.
- MSG_ENTER, 8'd68: UART byte sent before entering.
- MSG_EXIT, 8'd69: UART byte sent before exiting.
- CNT_W, 30: width of both internal counters. Every *_CYCLES value must be below 2**CNT_W.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: level request. Held high by the controller for the whole manoeuvre.
- mode, in, 1: 0 = enter (forward then reverse), 1 = exit (forward only). Sampled in IDLE.
- sensor_l, sensor_m, sensor_r, in, 1 each: line sensors, 1 = black.
- tx_ready, in, 1: UART can accept a byte.
- tx_data, out, 8: byte to transmit.
- tx_valid, out, 1: byte valid.
- motor_l_reset, motor_r_reset, out, 1 each: 1 = motor held off.
- motor_l_direction, out, 1: 1 = forward.
- motor_r_direction, out, 1: 0 = forward (mirrored mounting).
- motor_brake, out, 1: brake request.
- busy, out, 1: manoeuvre in progress.
- done, out, 1: manoeuvre completed.
- error, out, 1: reverse timeout occurred.

Behaviour:
- States: IDLE, SEND, FWD, FWD_GAP, REV, REV_GAP, DONE, FAULT.
- Registers:
  - state;
  - mode_q;
  - phase_cnt, which counts time in the FWD/REV phase and is not cleared by gaps;
  - period_cnt.
- All outputs are registered.

Reset and IDLE outputs:
- Reset value, and the IDLE value: state IDLE, both motor resets 1, both directions 0, brake 0, tx_valid 0, tx_data 0, busy/done/error 0, both counters 0.

IDLE:
- start=1: capture mode into mode_q, go to SEND.
- Otherwise remain in IDLE.

SEND:
- tx_data = MSG_EXIT if mode_q, else MSG_ENTER.
- Motors are held off and brake is 1.
- tx_valid is asserted in SEND.
- The byte transfers on the cycle tx_valid & tx_ready. That cycle goes to FWD with counters cleared.
- Exactly one byte is transferred per manoeuvre. tx_valid is 0 in every other state.

FWD:
- brake is 0; motors follow this steering table on {l,m,r}:
  - 000: both forward.
  - 001: left off, right forward.
  - 010: both forward.
  - 011: left reverse, right forward.
  - 100: left forward, right off.
  - 101: both forward.
  - 110: left forward, right reverse.
  - 111: both off.
- Exit priority:
  - phase_cnt == FWD_CYCLES-1: go to DONE if mode_q=1, else go to REV with counters cleared.
  - Else period_cnt == PERIOD_CYCLES-1: go to FWD_GAP.

FWD_GAP:
- One cycle with both motor resets 1.
- Clears period_cnt; phase_cnt keeps counting.
- Returns to FWD.

REV:
- Both motors run in reverse: left direction 0, right direction 1, resets 0.
- Exit priority:
  - Sensors 111: go to DONE.
  - Else phase_cnt == REV_MAX_CYCLES-1: go to FAULT.
  - Else period boundary: go to REV_GAP (same rules as FWD_GAP).

DONE:
- Motors off, brake 1, done 1, busy 0.
- Held until start=0, then go to IDLE.

FAULT:
- Motors off, brake 1, error 1.
- Held until start=0, then go to IDLE.

busy:
- 1 in SEND, FWD, FWD_GAP, REV and REV_GAP.

Abort and boundary rules:
- start=0 in any busy state: next cycle is IDLE with motors off. A byte not yet handshaken is dropped.
- Simultaneous phase end and period boundary: phase end wins, and no gap is inserted.
- tx_ready held low: SEND waits indefinitely with motors off.
- start re-asserted on the same cycle that DONE exits: IDLE is visited for at least one cycle before a new manoeuvre starts.

Decomposition:
- Package station_pkg:
  - station_state_t enum;
  - direction constants L_FWD=1, R_FWD=0;
  - function steer(l,m,r), which returns {l_reset, l_dir, r_reset, r_dir} per the table.
- Natural sub-module: station_steer, a combinational wrapper around steer(), shared with the plain line-follower block.
- Counters are inline.

Test Plan:
- Enter, happy path. FWD_CYCLES=100, PERIOD_CYCLES=20; start=1, mode=0, tx_ready=1; sensors 010, then 111 driven 30 cycles into REV.
  Required: one tx_valid/ready handshake with tx_data=68; 4 FWD_GAP cycles; REV outputs left dir 0, right dir 1; done=1 and brake=1 one cycle after 111 is seen.
- Exit. mode=1.
  Required: tx_data=69; DONE entered directly after 100 FWD cycles; no REV cycle; done held until start=0, then IDLE on the next cycle.
- Steering sweep in FWD. Apply each of the 8 sensor codes.
  Required: motor outputs match the table exactly, including 111 giving both motors off.
- Reverse timeout. REV_MAX_CYCLES=50, sensors never 111.
  Required: error=1 and brake=1 after 50 REV cycles; busy=0.
- UART backpressure. tx_ready=0 for 37 cycles.
  Required: remain in SEND with motors off and tx_valid=1; FWD entered on the cycle after tx_ready=1.
- Abort and reset. Drop start mid-FWD, then assert reset mid-REV.
  Required: both return to IDLE reset values within 1 cycle; counters are 0.
